// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_WORDS_DEFAULT = 1000;

  // Stores only have signed-width encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane extraction with extension for loads, and lane merge
// into a full word for read-modify-write stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{byte_off, 3'b000} +: 8];
    half_sel = word[{byte_off[1], 4'b0000} +: 16];
  end

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    store_data = word;
    case (funct3)
      F3_B:    store_data[{byte_off, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_data[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    store_data = wdata;
      default: store_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Pipeline-side initiator for a word-addressed data memory: one load or store
// in flight, sub-word stores done as read-modify-write.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request; faults are decided on accept
//   ST_READ  | mem_read asserted, memory word captured at the edge
//   ST_WRITE | mem_write asserted with the (merged) store word
//   ST_RESP  | rsp_valid pulse; rsp_rdata/rsp_fault already registered
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;

  logic        req_fault;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] store_data;

  always_comb begin
    misaligned = 1'b0;
    if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
      misaligned = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
      misaligned = 1'b1;
    out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    req_fault    = !f3_legal(req_we, req_funct3) || misaligned || out_of_range;
  end

  // Loads extract straight from the memory bus so the result is ready at the
  // READ edge; stores merge from the word captured at that edge.
  assign align_word = (state == ST_READ) ? mem_read_data : word_q;

  lsu_lane_align u_lane_align (
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .word       (align_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      word_q    <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_fault) begin
              rsp_rdata <= 32'h0;
              rsp_fault <= 1'b1;
              state     <= ST_RESP;
            end else if (req_we && req_funct3 == F3_W) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          word_q <= mem_read_data;
          if (we_q) begin
            state <= ST_WRITE;
          end else begin
            rsp_rdata <= load_data;
            rsp_fault <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          rsp_rdata <= 32'h0;
          rsp_fault <= 1'b0;
          state     <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready      = (state == ST_IDLE);
    rsp_valid      = (state == ST_RESP);
    mem_read       = (state == ST_READ);
    mem_write      = (state == ST_WRITE);
    mem_address    = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_write_data = mem_write ? store_data : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always_comb mem_read_data = mem_read ? mem[mem_address[11:2]] : 32'h0;

  always @(posedge clk) if (mem_write) mem[mem_address[11:2]] <= mem_write_data;

  // Issues one request and observes 8 cycles after the accept edge.
  task automatic run_access(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int rsp_cyc, output logic [31:0] rdata,
                            output logic fault, output int n_rd, output int n_wr,
                            output int n_both, output logic [31:0] rd_addr,
                            output logic [31:0] wr_addr, output logic [31:0] wr_data,
                            output logic [8:1] rdy);
    rsp_cyc = 0; rdata = 32'hDEAD_BEEF; fault = 1'bx;
    n_rd = 0; n_wr = 0; n_both = 0;
    rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0; rdy = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
      end
      rdy[n] = req_ready;
      if (mem_read)  begin n_rd++; rd_addr = mem_address; end
      if (mem_write) begin n_wr++; wr_addr = mem_address; wr_data = mem_write_data; end
      if (mem_read && mem_write) n_both++;
      if (rsp_valid && rsp_cyc == 0) begin
        rsp_cyc = n; rdata = rsp_rdata; fault = rsp_fault;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, mem_read, mem_write, rsp_fault} !== 5'b10000 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: ready/valid/rd/wr/fault=%b rdata=%h, expected 10000 / 0",
               {req_ready, rsp_valid, mem_read, mem_write, rsp_fault}, rsp_rdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, mem_read, mem_write, rsp_fault} !== 5'b10000 || rsp_rdata !== 32'h0
        || mem_address !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: ready/valid/rd/wr/fault=%b rdata=%h addr=%h, expected 10000 / 0 / 0",
               {req_ready, rsp_valid, mem_read, mem_write, rsp_fault}, rsp_rdata, mem_address);
    end
  endtask

  task automatic test_lw();
    int cyc, nr, nw, nb; logic [31:0] rd, ra, wa, wd; logic flt; logic [8:1] rdy;
    mem[4] = 32'h8765_4321;
    run_access(1'b0, 3'b010, 32'h10, 32'h0, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
    n_checks++;
    if (nr != 1 || ra !== 32'h10 || nw != 0) begin
      n_fail++;
      $display("FAIL lw_strobes: reads=%0d addr=%h writes=%0d, expected 1 / 00000010 / 0", nr, ra, nw);
    end
    n_checks++;
    if (cyc != 2 || rd !== 32'h8765_4321 || flt !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_rsp: cycle=%0d rdata=%h fault=%b, expected 2 / 87654321 / 0", cyc, rd, flt);
    end
    n_checks++;
    if (rdy[4:1] !== 4'b1100) begin
      n_fail++;
      $display("FAIL lw_ready: ready cycles 4..1=%b, expected 1100", rdy[4:1]);
    end
  endtask

  task automatic test_subword_loads();
    logic [2:0]  f3s  [0:6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100};
    logic [31:0] adrs [0:6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h12, 32'h10, 32'h10};
    logic [31:0] exps [0:6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                32'hFFFF_FFFF, 32'h0000_0011, 32'h0000_0011};
    int cyc, nr, nw, nb; logic [31:0] rd, ra, wa, wd; logic flt; logic [8:1] rdy;
    mem[4] = 32'h80FF_0011;
    for (int i = 0; i < 7; i++) begin
      run_access(1'b0, f3s[i], adrs[i], 32'h0, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
      n_checks++;
      if (cyc != 2 || rd !== exps[i] || flt !== 1'b0 || nr != 1) begin
        n_fail++;
        $display("FAIL subword_load[%0d] f3=%b addr=%h: cycle=%0d rdata=%h fault=%b reads=%0d, expected 2 / %h / 0 / 1",
                 i, f3s[i], adrs[i], cyc, rd, flt, nr, exps[i]);
      end
    end
  endtask

  task automatic test_stores();
    int cyc, nr, nw, nb; logic [31:0] rd, ra, wa, wd; logic flt; logic [8:1] rdy;
    mem[8] = 32'h1122_3344;
    run_access(1'b1, 3'b000, 32'h21, 32'hAABB_CCDD, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
    n_checks++;
    if (nr != 1 || nw != 1 || wa !== 32'h20 || wd !== 32'h1122_DD44 || nb != 0) begin
      n_fail++;
      $display("FAIL sb_rmw: reads=%0d writes=%0d waddr=%h wdata=%h both=%0d, expected 1 / 1 / 00000020 / 1122dd44 / 0",
               nr, nw, wa, wd, nb);
    end
    n_checks++;
    if (cyc != 3 || rd !== 32'h0 || flt !== 1'b0 || rdy[5:1] !== 5'b11000) begin
      n_fail++;
      $display("FAIL sb_rsp: cycle=%0d rdata=%h fault=%b ready=%b, expected 3 / 0 / 0 / 11000", cyc, rd, flt, rdy[5:1]);
    end
    run_access(1'b0, 3'b010, 32'h20, 32'h0, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
    n_checks++;
    if (rd !== 32'h1122_DD44) begin
      n_fail++;
      $display("FAIL sb_readback: rdata=%h, expected 1122dd44", rd);
    end
    run_access(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
    n_checks++;
    if (cyc != 3 || wd !== 32'hBEEF_DD44 || nw != 1) begin
      n_fail++;
      $display("FAIL sh_rmw: cycle=%0d wdata=%h writes=%0d, expected 3 / beefdd44 / 1", cyc, wd, nw);
    end
    run_access(1'b1, 3'b000, 32'h23, 32'h0000_0077, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
    n_checks++;
    if (wd !== 32'h77EF_DD44) begin
      n_fail++;
      $display("FAIL sb_lane3: wdata=%h, expected 77efdd44", wd);
    end
    run_access(1'b1, 3'b010, 32'h24, 32'hCAFE_F00D, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
    n_checks++;
    if (cyc != 2 || nr != 0 || nw != 1 || wa !== 32'h24 || wd !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL sw: cycle=%0d reads=%0d writes=%0d waddr=%h wdata=%h, expected 2 / 0 / 1 / 00000024 / cafef00d",
               cyc, nr, nw, wa, wd);
    end
    run_access(1'b0, 3'b010, 32'h24, 32'h0, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
    n_checks++;
    if (rd !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL sw_readback: rdata=%h, expected cafef00d", rd);
    end
  endtask

  task automatic test_faults();
    logic        wes  [0:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s  [0:6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010, 3'b101};
    logic [31:0] adrs [0:6] = '{32'h2, 32'h5, 32'hFA0, 32'h0, 32'h8, 32'hF9C, 32'h13};
    logic        flts [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int cyc, nr, nw, nb; logic [31:0] rd, ra, wa, wd; logic flt; logic [8:1] rdy;
    logic [31:0] exp_rd;
    int exp_cyc, exp_acc;
    mem[999] = 32'h0BAD_F00D;
    for (int i = 0; i < 7; i++) begin
      run_access(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, cyc, rd, flt, nr, nw, nb, ra, wa, wd, rdy);
      exp_rd  = flts[i] ? 32'h0 : 32'h0BAD_F00D;
      exp_cyc = flts[i] ? 1 : 2;
      exp_acc = flts[i] ? 0 : 1;
      n_checks++;
      if (cyc != exp_cyc || flt !== flts[i] || rd !== exp_rd || nr != exp_acc || nw != 0) begin
        n_fail++;
        $display("FAIL fault[%0d] we=%b f3=%b addr=%h: cycle=%0d fault=%b rdata=%h reads=%0d writes=%0d, expected %0d / %b / %h / %0d / 0",
                 i, wes[i], f3s[i], adrs[i], cyc, flt, rd, nr, nw, exp_cyc, flts[i], exp_rd, exp_acc);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int n_wr = 0, n_rsp = 0;
    logic rd_seen;
    mem[16] = 32'h5A5A_5A5A;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h40; req_wdata = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    rd_seen = mem_read;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_seen !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: read_before=%b read=%b write=%b ready=%b valid=%b, expected 1 / 0 / 0 / 1 / 0",
               rd_seen, mem_read, mem_write, req_ready, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (mem_write) n_wr++;
      if (rsp_valid) n_rsp++;
    end
    n_checks++;
    if (n_wr != 0 || n_rsp != 0 || req_ready !== 1'b1 || mem[16] !== 32'h5A5A_5A5A) begin
      n_fail++;
      $display("FAIL reset_mid_after: writes=%0d rsps=%0d ready=%b word=%h, expected 0 / 0 / 1 / 5a5a5a5a",
               n_wr, n_rsp, req_ready, mem[16]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_lw();
    test_subword_loads();
    test_stores();
    test_faults();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
